mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multicycle control unit for the 16-bit, 8-register CPU. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives all datapath control lines, including the 2-bit select of the 3-bit register-write-address mux and the ALU/PC source muxes. It sits directly upstream of those muxes and handshakes with the unified instruction/data memory through a req/ack pair.

## Interface
Parameters:
- none. Encodings are fixed by this document.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  4  IR[15:12], valid from DECODE onward.
- zero  in  1  ALU zero flag, used for BEQ.
- mem_ack  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request; held until mem_ack.
- mem_we  out  1  write enable; qualified by mem_req.
- iord  out  1  address source: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero = 1.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- reg_write  out  1  register file write.
- reg_dst_sel  out  2  write-address mux select: 00 = rt, 01 = rd, 10 = r7 (link), 11 = unused.
- mem_to_reg  out  2  write-data source: 00 = ALUOut, 01 = MDR, 10 = PC.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B input: 00 = B register, 01 = constant 1, 10 = sign-extended imm6.
- alu_op  out  2  ALU operation: 00 = add, 01 = subtract, 10 = use funct.
- halted  out  1  FSM is in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Opcodes: 0000 R-type, 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 0101 J, 0110 JAL, 1111 HALT. All other opcodes are illegal.
- States and outputs (any output not listed is 0):
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. When mem_ack=1, ir_write=1, pc_write=1 and pc_src=00 (Mealy outputs) and the FSM goes to DECODE. Otherwise it stays in FETCH.
  - DECODE: alu_src_a=0, alu_src_b=10, alu_op=00, which precomputes the branch target. The next state is chosen by opcode: R to EXEC_R; ADDI, LW and SW to ADDR; BEQ to BRANCH; J to JUMP; JAL to JAL; HALT to HALT; illegal opcodes to FETCH with illegal=1.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Next state is WB_R.
  - WB_R: reg_write=1, reg_dst_sel=01, mem_to_reg=00. Next state is FETCH.
  - ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. ADDI goes to WB_I, LW to MEM_RD, SW to MEM_WR.
  - WB_I: reg_write=1, reg_dst_sel=00, mem_to_reg=00. Next state is FETCH.
  - MEM_RD: mem_req=1, iord=1. Stays until mem_ack, then goes to WB_MEM.
  - WB_MEM: reg_write=1, reg_dst_sel=00, mem_to_reg=01. Next state is FETCH.
  - MEM_WR: mem_req=1, mem_we=1, iord=1. Stays until mem_ack, then goes to FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. Next state is FETCH.
  - JUMP: pc_write=1, pc_src=10. Next state is FETCH.
  - JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst_sel=10, mem_to_reg=10. Next state is FETCH.
  - HALT: halted=1. The FSM stays in HALT until reset.
- All outputs other than the FETCH ack-qualified signals decode from the state register only (Moore).

## Timing
- Reset: rst_n=0 sampled at a rising edge puts the FSM in FETCH.
  - During reset, all outputs are forced to 0, including mem_req, halted and illegal.
  - Reset overrides any state, including mid-access in MEM_RD or MEM_WR and HALT; there is no pending access after reset.
- The first mem_req=1 appears in the first cycle with rst_n=1.
- Cycle counts with zero-wait memory (mem_ack in the first req cycle):
  - R and ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, J and JAL: 3 cycles.
  - HALT and illegal: 2 cycles to reach HALT, or to return to FETCH.
- Each memory wait cycle adds one cycle to the instruction.
- While mem_ack=0, the FSM holds the request: mem_req, mem_we and iord stay stable every cycle.
- mem_ack is ignored outside FETCH, MEM_RD and MEM_WR.
- opcode is sampled only in DECODE and ADDR; changes at other times have no effect.
- reg_write and pc_write are never asserted in the same cycle, except in JAL.
- Exactly one reg_write pulse per writeback instruction.

## Test plan
- Reset, then opcode=0000, mem_ack tied to 1:
  - States go FETCH, DECODE, EXEC_R, WB_R, FETCH.
  - reg_write=1 with reg_dst_sel=01 in cycle 4 only.
  - ir_write=1 and pc_write=1 in cycle 1.
- LW with 2 wait cycles in MEM_RD:
  - mem_req=1 and iord=1 held for 3 cycles.
  - Then WB_MEM with mem_to_reg=01 and reg_dst_sel=00.
  - Total of 7 cycles.
- SW with mem_ack delayed 3 cycles in FETCH:
  - ir_write is asserted only in the ack cycle.
  - MEM_WR has mem_we=1.
  - No reg_write is seen at any point.
- BEQ with zero=1, and again with zero=0:
  - pc_write_cond=1 and pc_src=01 in cycle 3 in both cases.
  - alu_op=01 in cycle 3.
- JAL:
  - Cycle 3 shows pc_write=1, pc_src=10, reg_write=1, reg_dst_sel=10 and mem_to_reg=10.
- Opcode 1010:
  - illegal=1 for exactly one cycle in DECODE, then back to FETCH.
- Opcode 1111:
  - halted stays 1 indefinitely with mem_req=0.
- Reset mid-operation:
  - Assert rst_n=0 during an MEM_RD wait; the FSM returns to FETCH with all outputs 0.
  - Repeat from HALT; the FSM leaves HALT and returns to FETCH.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM for the 16-bit, 8-register CPU: sequences fetch,
// decode, execute, memory and writeback, and drives every datapath control line.
module mc_ctrl_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst_sel,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_WB_R   = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_WB_I   = 4'd5;
  localparam logic [3:0] S_MEM_RD = 4'd6;
  localparam logic [3:0] S_WB_MEM = 4'd7;
  localparam logic [3:0] S_MEM_WR = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_JAL    = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd12;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_J    = 4'b0101;
  localparam logic [3:0] OP_JAL  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  logic [3:0] state_r;
  logic [3:0] next_state_s;

  // The branch decision itself is made in the datapath via pc_write_cond.
  logic unused_zero_s;
  assign unused_zero_s = zero;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (mem_ack) next_state_s = S_DECODE;
        else         next_state_s = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:    next_state_s = S_EXEC_R;
          OP_ADDI: next_state_s = S_ADDR;
          OP_LW:   next_state_s = S_ADDR;
          OP_SW:   next_state_s = S_ADDR;
          OP_BEQ:  next_state_s = S_BRANCH;
          OP_J:    next_state_s = S_JUMP;
          OP_JAL:  next_state_s = S_JAL;
          OP_HALT: next_state_s = S_HALT;
          default: next_state_s = S_FETCH;
        endcase
      end
      S_EXEC_R: next_state_s = S_WB_R;
      S_ADDR: begin
        case (opcode)
          OP_ADDI: next_state_s = S_WB_I;
          OP_LW:   next_state_s = S_MEM_RD;
          OP_SW:   next_state_s = S_MEM_WR;
          default: next_state_s = S_FETCH;
        endcase
      end
      S_MEM_RD: begin
        if (mem_ack) next_state_s = S_WB_MEM;
        else         next_state_s = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ack) next_state_s = S_FETCH;
        else         next_state_s = S_MEM_WR;
      end
      S_HALT:  next_state_s = S_HALT;
      default: next_state_s = S_FETCH;
    endcase
  end

  // Output decode; all lines are held low while reset is asserted.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    reg_write     = 1'b0;
    reg_dst_sel   = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    halted        = 1'b0;
    illegal       = 1'b0;
    if (!rst_n) begin
      mem_req = 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end else begin
            ir_write = 1'b0;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b10;
          case (opcode)
            OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_HALT: illegal = 1'b0;
            default: illegal = 1'b1;
          endcase
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_WB_R: begin
          reg_write   = 1'b1;
          reg_dst_sel = 2'b01;
        end
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_WB_I: reg_write = 1'b1;
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        S_JAL: begin
          pc_write    = 1'b1;
          pc_src      = 2'b10;
          reg_write   = 1'b1;
          reg_dst_sel = 2'b10;
          mem_to_reg  = 2'b10;
        end
        S_HALT:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed table-driven bench for mc_ctrl_fsm; every output is packed into one
// 20-bit word and compared against hand-computed per-state constants.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, reg_dst_sel, mem_to_reg, alu_src_b, alu_op;
  logic       reg_write, alu_src_a, halted, illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst_sel(reg_dst_sel), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .halted(halted), .illegal(illegal)
  );

  // Word layout: mem_req mem_we iord ir_write pc_write pc_write_cond pc_src[2]
  //   reg_write reg_dst_sel[2] mem_to_reg[2] alu_src_a alu_src_b[2] alu_op[2] halted illegal
  logic [19:0] got;
  assign got = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                reg_write, reg_dst_sel, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                halted, illegal};

  localparam logic [19:0] E_ZERO    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [19:0] E_FETCH_W = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0};
  localparam logic [19:0] E_FETCH_A = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0};
  localparam logic [19:0] E_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,2'b10,2'b00,1'b0,1'b0};
  localparam logic [19:0] E_DEC_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,2'b10,2'b00,1'b0,1'b1};
  localparam logic [19:0] E_EXEC_R  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,2'b00,2'b10,1'b0,1'b0};
  localparam logic [19:0] E_WB_R    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b01,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [19:0] E_ADDR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0};
  localparam logic [19:0] E_WB_I    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [19:0] E_MEM_RD  = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [19:0] E_WB_MEM  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b01,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [19:0] E_MEM_WR  = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [19:0] E_BRANCH  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b0,2'b00,2'b00,1'b1,2'b00,2'b01,1'b0,1'b0};
  localparam logic [19:0] E_JUMP    = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [19:0] E_JAL     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,1'b1,2'b10,2'b10,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [19:0] E_HALT    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0};

  typedef struct {
    logic        rst_n;
    logic [3:0]  opcode;
    logic        zero;
    logic        ack;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] op, input logic z,
                     input logic a, input logic [19:0] e);
    vec_t v;
    v.rst_n = r; v.opcode = op; v.zero = z; v.ack = a; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, compare on the falling edge, then step the clock.
  task automatic step(input logic r, input logic [3:0] op, input logic z,
                      input logic a, input logic [19:0] e, input string name);
    rst_n = r; opcode = op; zero = z; mem_ack = a;
    @(negedge clk);
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: got %05h want %05h", name, got, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 4'b0000; zero = 1'b0; mem_ack = 1'b1;

    // Reset with ack high: outputs must still be zero
    add(1'b0, 4'b0000, 1'b0, 1'b1, E_ZERO);
    add(1'b0, 4'b0000, 1'b0, 1'b1, E_ZERO);
    // R-type, zero-wait: 4 cycles
    add(1'b1, 4'b0000, 1'b0, 1'b1, E_FETCH_A);
    add(1'b1, 4'b0000, 1'b0, 1'b1, E_DECODE);
    add(1'b1, 4'b0000, 1'b0, 1'b1, E_EXEC_R);
    add(1'b1, 4'b0000, 1'b0, 1'b1, E_WB_R);
    // ADDI: 4 cycles
    add(1'b1, 4'b0001, 1'b0, 1'b1, E_FETCH_A);
    add(1'b1, 4'b0001, 1'b0, 1'b1, E_DECODE);
    add(1'b1, 4'b0001, 1'b0, 1'b1, E_ADDR);
    add(1'b1, 4'b0001, 1'b0, 1'b1, E_WB_I);
    // LW with two MEM_RD wait cycles: 7 cycles
    add(1'b1, 4'b0010, 1'b0, 1'b1, E_FETCH_A);
    add(1'b1, 4'b0010, 1'b0, 1'b1, E_DECODE);
    add(1'b1, 4'b0010, 1'b0, 1'b1, E_ADDR);
    add(1'b1, 4'b0010, 1'b0, 1'b0, E_MEM_RD);
    add(1'b1, 4'b0010, 1'b0, 1'b0, E_MEM_RD);
    add(1'b1, 4'b0010, 1'b0, 1'b1, E_MEM_RD);
    add(1'b1, 4'b0010, 1'b0, 1'b1, E_WB_MEM);
    // SW with three FETCH wait cycles; opcode noise during fetch is ignored
    add(1'b1, 4'b1111, 1'b0, 1'b0, E_FETCH_W);
    add(1'b1, 4'b0101, 1'b0, 1'b0, E_FETCH_W);
    add(1'b1, 4'b1010, 1'b0, 1'b0, E_FETCH_W);
    add(1'b1, 4'b0011, 1'b0, 1'b1, E_FETCH_A);
    add(1'b1, 4'b0011, 1'b0, 1'b1, E_DECODE);
    add(1'b1, 4'b0011, 1'b0, 1'b1, E_ADDR);
    add(1'b1, 4'b0011, 1'b0, 1'b1, E_MEM_WR);
    // BEQ zero=1 then zero=0: identical control
    add(1'b1, 4'b0100, 1'b1, 1'b1, E_FETCH_A);
    add(1'b1, 4'b0100, 1'b1, 1'b1, E_DECODE);
    add(1'b1, 4'b0100, 1'b1, 1'b1, E_BRANCH);
    add(1'b1, 4'b0100, 1'b0, 1'b1, E_FETCH_A);
    add(1'b1, 4'b0100, 1'b0, 1'b1, E_DECODE);
    add(1'b1, 4'b0100, 1'b0, 1'b1, E_BRANCH);
    // J and JAL
    add(1'b1, 4'b0101, 1'b0, 1'b1, E_FETCH_A);
    add(1'b1, 4'b0101, 1'b0, 1'b1, E_DECODE);
    add(1'b1, 4'b0101, 1'b0, 1'b1, E_JUMP);
    add(1'b1, 4'b0110, 1'b0, 1'b1, E_FETCH_A);
    add(1'b1, 4'b0110, 1'b0, 1'b1, E_DECODE);
    add(1'b1, 4'b0110, 1'b0, 1'b1, E_JAL);
    // Illegal opcode: one-cycle pulse then back to FETCH
    add(1'b1, 4'b1010, 1'b0, 1'b1, E_FETCH_A);
    add(1'b1, 4'b1010, 1'b0, 1'b1, E_DEC_ILL);
    add(1'b1, 4'b1010, 1'b0, 1'b0, E_FETCH_W);
    // Reset during MEM_RD wait: no pending access afterwards
    add(1'b1, 4'b0010, 1'b0, 1'b1, E_FETCH_A);
    add(1'b1, 4'b0010, 1'b0, 1'b1, E_DECODE);
    add(1'b1, 4'b0010, 1'b0, 1'b0, E_ADDR);
    add(1'b1, 4'b0010, 1'b0, 1'b0, E_MEM_RD);
    add(1'b0, 4'b0010, 1'b0, 1'b0, E_ZERO);
    add(1'b1, 4'b0010, 1'b0, 1'b0, E_FETCH_W);
    // HALT entry
    add(1'b1, 4'b1111, 1'b0, 1'b1, E_FETCH_A);
    add(1'b1, 4'b1111, 1'b0, 1'b1, E_DECODE);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].opcode, vecs[i].zero, vecs[i].ack, vecs[i].exp,
           $sformatf("vec%0d", i));
    end

    // HALT is sticky regardless of ack/opcode activity
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 4'(k), 1'(k % 3), 1'(k % 2), E_HALT, $sformatf("halt%0d", k));
    end

    // Reset out of HALT, then a fresh fetch
    step(1'b0, 4'b1111, 1'b0, 1'b1, E_ZERO, "halt_rst");
    step(1'b1, 4'b0000, 1'b0, 1'b1, E_FETCH_A, "post_halt_fetch");
    step(1'b1, 4'b0000, 1'b0, 1'b1, E_DECODE, "post_halt_decode");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
